// File: rtl/display_bcd_scheduler_if.sv
// Request strobes, operands and display outputs of the shared BCD display scheduler.
// The master side drives requests; the slave side is the scheduler.
interface display_bcd_scheduler_if;
  logic        out;
  logic        in;
  logic [31:0] dados;
  logic [31:0] entrada;
  logic [31:0] endereco;
  logic [31:0] saida;
  logic [31:0] segmentos;
  logic [31:0] segmentosPrograma;
  logic        neg;
  logic        busy;
  logic        done;

  modport master (
    output out, in, dados, entrada, endereco,
    input  saida, segmentos, segmentosPrograma, neg, busy, done
  );

  modport slave (
    input  out, in, dados, entrada, endereco,
    output saida, segmentos, segmentosPrograma, neg, busy, done
  );
endinterface

// File: rtl/display_bcd_scheduler.sv
// Time-shared iterative double-dabble converter feeding the data and program-address
// 7-segment displays; fixed priority out > in > pc with merged pending requests.
module display_bcd_scheduler #(
  parameter int unsigned DIGITS   = 8,
  parameter int unsigned MAG_BITS = 31,
  parameter bit          PC_AUTO  = 1'b1
) (
  input logic                     clock,
  input logic                     resetn,
  display_bcd_scheduler_if.slave  bus
);

  localparam int unsigned BCD_W = 4 * DIGITS;
  localparam int unsigned CNT_W = (MAG_BITS > 1) ? $clog2(MAG_BITS) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MAG_BITS - 1);

  typedef enum logic [1:0] {IDLE, LOAD, SHIFT, COMMIT} state_t;
  typedef enum logic [1:0] {SRC_OUT, SRC_IN, SRC_PC} src_t;

  state_t state, state_n;
  src_t   src;

  logic              pend_out, pend_in, pend_pc;
  logic [31:0]       hold_out, hold_in, hold_pc, pc_ref;
  logic [BCD_W-1:0]  bcd;
  logic [MAG_BITS-1:0] mag;
  logic              sgn;
  logic [CNT_W-1:0]  cnt;
  logic [31:0]       raw;

  logic [31:0]       saida_q, seg_q, segp_q;
  logic              neg_q, busy_q, done_q;
  logic              busy_n, done_n;

  logic              grant_out_c, grant_in_c, grant_pc_c, grant_any_c;
  logic              pc_req_c;
  logic [MAG_BITS-1:0] load_mag_c;
  logic              load_sgn_c;
  logic [31:0]       load_raw_c;
  src_t              load_src_c;
  logic [BCD_W-1:0]  bcd_adj_c;

  // Fixed-priority grant, only evaluated while idle.
  always_comb begin
    grant_out_c = (state == IDLE) && pend_out;
    grant_in_c  = (state == IDLE) && !pend_out && pend_in;
    grant_pc_c  = (state == IDLE) && !pend_out && !pend_in && pend_pc;
    grant_any_c = grant_out_c || grant_in_c || grant_pc_c;
    pc_req_c    = PC_AUTO && (bus.endereco != pc_ref);
  end

  // Operand selection for the granted source; OUT operands are signed.
  always_comb begin
    load_src_c = SRC_PC;
    load_sgn_c = 1'b0;
    load_raw_c = hold_pc;
    load_mag_c = MAG_BITS'(hold_pc);
    if (pend_out) begin
      load_src_c = SRC_OUT;
      load_sgn_c = hold_out[31];
      load_raw_c = hold_out;
      load_mag_c = MAG_BITS'(hold_out[31] ? (~hold_out + 32'd1) : hold_out);
    end else if (pend_in) begin
      load_src_c = SRC_IN;
      load_raw_c = hold_in;
      load_mag_c = MAG_BITS'(hold_in);
    end
  end

  // Add-3 correction of every BCD nibble that is 5 or more.
  always_comb begin
    bcd_adj_c = bcd;
    for (int i = 0; i < int'(DIGITS); i++) begin
      if (bcd[4*i +: 4] >= 4'd5) bcd_adj_c[4*i +: 4] = bcd[4*i +: 4] + 4'd3;
    end
  end

  // Next state and registered status outputs.
  always_comb begin
    state_n = state;
    done_n  = 1'b0;
    case (state)
      IDLE:        if (grant_any_c) state_n = LOAD;
      LOAD, SHIFT: state_n = (cnt == CNT_LAST) ? COMMIT : SHIFT;
      COMMIT: begin
        state_n = IDLE;
        done_n  = 1'b1;
      end
      default:     state_n = IDLE;
    endcase
    busy_n = (state_n != IDLE);
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state  <= IDLE;
      busy_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      state  <= state_n;
      busy_q <= busy_n;
      done_q <= done_n;
    end
  end

  // Request capture: a new strobe beats a same-edge grant and the newest operand wins.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      pend_out <= 1'b0;
      pend_in  <= 1'b0;
      pend_pc  <= 1'b0;
      hold_out <= '0;
      hold_in  <= '0;
      hold_pc  <= '0;
    end else begin
      pend_out <= bus.out  | (pend_out & ~grant_out_c);
      pend_in  <= bus.in   | (pend_in  & ~grant_in_c);
      pend_pc  <= pc_req_c | (pend_pc  & ~grant_pc_c);
      if (bus.out) hold_out <= bus.dados;
      if (bus.in)  hold_in  <= bus.entrada;
      if (pc_req_c) hold_pc <= bus.endereco;
    end
  end

  // Conversion datapath and atomic display commit. The grant edge loads the
  // operand, so the LOAD cycle already performs the first shift.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      src     <= SRC_OUT;
      bcd     <= '0;
      mag     <= '0;
      sgn     <= 1'b0;
      cnt     <= '0;
      raw     <= '0;
      pc_ref  <= '0;
      saida_q <= '0;
      seg_q   <= '0;
      segp_q  <= '0;
      neg_q   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (grant_any_c) begin
            src <= load_src_c;
            bcd <= '0;
            mag <= load_mag_c;
            sgn <= load_sgn_c;
            raw <= load_raw_c;
            cnt <= '0;
          end
        end
        LOAD, SHIFT: begin
          bcd <= {bcd_adj_c[BCD_W-2:0], mag[MAG_BITS-1]};
          mag <= {mag[MAG_BITS-2:0], 1'b0};
          cnt <= cnt + CNT_W'(1);
        end
        COMMIT: begin
          if (src == SRC_PC) begin
            segp_q <= 32'(bcd);
            pc_ref <= hold_pc;
          end else begin
            seg_q   <= 32'(bcd);
            saida_q <= raw;
            neg_q   <= sgn;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.saida             = saida_q;
  assign bus.segmentos         = seg_q;
  assign bus.segmentosPrograma = segp_q;
  assign bus.neg               = neg_q;
  assign bus.busy              = busy_q;
  assign bus.done              = done_q;

endmodule

// File: tb/tb_display_bcd_scheduler.sv
// Scoreboard bench for display_bcd_scheduler: directed requests push expected
// display contents; a monitor pops and compares on every done pulse.
module tb_display_bcd_scheduler;

  logic clock  = 1'b0;
  logic resetn = 1'b0;

  display_bcd_scheduler_if bus ();

  display_bcd_scheduler dut (
    .clock  (clock),
    .resetn (resetn),
    .bus    (bus)
  );

  always #5 clock = ~clock;

  typedef struct packed {
    logic [31:0] seg;
    logic [31:0] saida;
    logic [31:0] segp;
    logic        neg;
  } exp_t;

  exp_t exp_q[$];
  int   vectors    = 0;
  int   miscompares = 0;
  int   done_seen  = 0;

  // Model of the current display contents, advanced as expectations are pushed.
  logic [31:0] m_seg = '0, m_saida = '0, m_segp = '0;
  logic        m_neg = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic push_data(input logic [31:0] seg, input logic [31:0] saida, input logic neg);
    exp_t e;
    m_seg = seg; m_saida = saida; m_neg = neg;
    e.seg = m_seg; e.saida = m_saida; e.segp = m_segp; e.neg = m_neg;
    exp_q.push_back(e);
  endtask

  task automatic push_pc(input logic [31:0] segp);
    exp_t e;
    m_segp = segp;
    e.seg = m_seg; e.saida = m_saida; e.segp = m_segp; e.neg = m_neg;
    exp_q.push_back(e);
  endtask

  // Monitor: every done pulse must match the oldest expectation.
  always @(negedge clock) begin
    if (resetn && bus.done) begin
      done_seen++;
      if (exp_q.size() == 0) begin
        vectors++;
        miscompares++;
        $display("FAIL unexpected_done: got done=1 expected no commit at %0t", $time);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        chk("segmentos", bus.segmentos, e.seg);
        chk("saida", bus.saida, e.saida);
        chk("segmentosPrograma", bus.segmentosPrograma, e.segp);
        chk("neg", 32'(bus.neg), 32'(e.neg));
      end
    end
  end

  // Strobe held across exactly one rising edge; returns on the negedge after it.
  task automatic strobe(input logic o, input logic i, input logic [31:0] d, input logic [31:0] e);
    @(negedge clock);
    bus.out = o;
    bus.in  = i;
    if (o) bus.dados   = d;
    if (i) bus.entrada = e;
    @(negedge clock);
    bus.out = 1'b0;
    bus.in  = 1'b0;
  endtask

  task automatic drain(input string name);
    int n;
    n = 0;
    while ((exp_q.size() != 0 || bus.busy) && n < 400) begin
      @(negedge clock);
      n++;
    end
    if (n >= 400) chk({name, "_timeout"}, 32'(exp_q.size()), 32'd0);
    repeat (3) @(negedge clock);
  endtask

  initial begin
    int n;
    int d0;
    bus.out = 1'b0; bus.in = 1'b0;
    bus.dados = '0; bus.entrada = '0; bus.endereco = '0;

    repeat (3) @(negedge clock);
    chk("rst_segmentos", bus.segmentos, 32'd0);
    chk("rst_saida", bus.saida, 32'd0);
    chk("rst_segp", bus.segmentosPrograma, 32'd0);
    chk("rst_flags", {29'd0, bus.neg, bus.busy, bus.done}, 32'd0);
    resetn = 1'b1;
    repeat (2) @(negedge clock);

    // out 123: latency to done and busy envelope.
    push_data(32'h00000123, 32'd123, 1'b0);
    strobe(1'b1, 1'b0, 32'd123, 32'd0);
    chk("busy_before_grant", 32'(bus.busy), 32'd0);
    n = 0;
    while (!bus.done && n < 100) begin
      @(negedge clock);
      n++;
      if (n == 1) chk("busy_after_grant", 32'(bus.busy), 32'd1);
    end
    chk("latency", 32'(n), 32'd33);
    @(negedge clock);
    chk("done_one_cycle", 32'(bus.done), 32'd0);
    chk("busy_after_commit", 32'(bus.busy), 32'd0);
    drain("t1");

    // Signed negative OUT, then large IN.
    push_data(32'h00000045, 32'hFFFFFFD3, 1'b1);
    strobe(1'b1, 1'b0, 32'hFFFFFFD3, 32'd0);
    drain("t2a");
    push_data(32'h99999999, 32'd99999999, 1'b0);
    strobe(1'b0, 1'b1, 32'd0, 32'd99999999);
    drain("t2b");

    // Simultaneous out and in: serviced back to back, out first.
    d0 = done_seen;
    push_data(32'h00000007, 32'd7, 1'b0);
    push_data(32'h00000008, 32'd8, 1'b0);
    strobe(1'b1, 1'b1, 32'd7, 32'd8);
    drain("t3");
    chk("dual_done_count", 32'(done_seen - d0), 32'd2);

    // Address change during an OUT conversion. The address stays unequal to the
    // committed reference until the first pc commit, so it converts twice.
    push_data(32'h00000005, 32'd5, 1'b0);
    push_pc(32'h00000016);
    push_pc(32'h00000016);
    strobe(1'b1, 1'b0, 32'd5, 32'd0);
    repeat (5) @(negedge clock);
    bus.endereco = 32'h10;
    drain("t4");
    chk("pc_data_kept", bus.segmentos, 32'h00000005);

    // Digit overflow beyond 8 digits and the most negative OUT value.
    push_data(32'h23456789, 32'd123456789, 1'b0);
    strobe(1'b0, 1'b1, 32'd0, 32'd123456789);
    drain("t5a");
    push_data(32'h00000000, 32'h80000000, 1'b1);
    strobe(1'b1, 1'b0, 32'h80000000, 32'd0);
    drain("t5b");

    // Reset mid-SHIFT aborts the conversion with no commit.
    d0 = done_seen;
    strobe(1'b1, 1'b0, 32'd42, 32'd0);
    repeat (10) @(negedge clock);
    chk("busy_mid_shift", 32'(bus.busy), 32'd1);
    #2 resetn = 1'b0;
    #1;
    chk("abort_segmentos", bus.segmentos, 32'd0);
    chk("abort_saida", bus.saida, 32'd0);
    chk("abort_segp", bus.segmentosPrograma, 32'd0);
    chk("abort_flags", {29'd0, bus.neg, bus.busy, bus.done}, 32'd0);
    m_seg = '0; m_saida = '0; m_segp = '0; m_neg = 1'b0;
    bus.endereco = 32'd0;
    repeat (2) @(negedge clock);
    resetn = 1'b1;
    repeat (45) @(negedge clock);
    chk("abort_no_done", 32'(done_seen - d0), 32'd0);
    chk("abort_idle", 32'(bus.busy), 32'd0);

    // Normal operation after the aborted conversion.
    push_data(32'h00000001, 32'd1, 1'b0);
    strobe(1'b1, 1'b0, 32'd1, 32'd0);
    drain("t7");
    chk("queue_empty", 32'(exp_q.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
